// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the CPU bus arbiter
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2
   } arb_state_t;

   localparam logic [3:0] BYTEENABLE_WORD = 4'b1111;

   // Encoding of last_grant and of the arbitration winner
   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'd15) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select between instruction and data requesters
import cpu_bus_pkg::*;

module arb_pick #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       req_i,
   input  logic       req_d,
   input  logic       last_grant,
   input  logic [3:0] starve_cnt,
   input  logic       mode,
   output logic       winner,
   output logic       none
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Single requester wins outright; on contention alternate (mode=1) or favour D until I starves
   always_comb begin
      none   = ~req_i & ~req_d;
      winner = SEL_D;
      if (req_i && !req_d) begin
         winner = SEL_I;
      end else if (req_i && req_d) begin
         if (mode) begin
            winner = ~last_grant;
         end else begin
            winner = (starve_cnt >= LIMIT) ? SEL_I : SEL_D;
         end
      end
   end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - two-requester Avalon master port arbiter with transfer-atomic grants
import cpu_bus_pkg::*;

module avalon_bus_arbiter #(
   parameter bit ROUND_ROBIN  = 1'b1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        grant_i,
   output logic        grant_d
);

   arb_state_t state;
   arb_state_t state_next;
   arb_state_t pick_state;
   logic       last_grant;
   logic [3:0] starve_cnt;

   logic       req_i;
   logic       req_d;
   logic       done_i;
   logic       done_d;
   logic       pick_last;
   logic [3:0] pick_cnt;
   logic       winner;
   logic       none;

   assign req_i  = i_read;
   assign req_d  = d_read | d_write;
   assign done_i = (state == ARB_GRANT_I) & req_i & ~waitrequest;
   assign done_d = (state == ARB_GRANT_D) & req_d & ~waitrequest;

   // Arbitrate on post-completion history so back-to-back picks already see this transfer
   always_comb begin
      pick_last = last_grant;
      pick_cnt  = starve_cnt;
      if (done_i) begin
         pick_last = SEL_I;
      end
      if (done_d) begin
         pick_last = SEL_D;
         if (req_i) begin
            pick_cnt = sat_inc4(starve_cnt);
         end
      end
   end

   arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .req_i      (req_i),
      .req_d      (req_d),
      .last_grant (pick_last),
      .starve_cnt (pick_cnt),
      .mode       (ROUND_ROBIN),
      .winner     (winner),
      .none       (none)
   );

   assign pick_state = none ? ARB_IDLE : (winner ? ARB_GRANT_D : ARB_GRANT_I);

   // Next state and bus mux; the granted requester drives the bus straight through
   always_comb begin
      state_next    = state;
      address       = 32'h0;
      read          = 1'b0;
      write         = 1'b0;
      writedata     = 32'h0;
      byteenable    = 4'h0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      case (state)
         ARB_IDLE: begin
            state_next = pick_state;
         end
         ARB_GRANT_I: begin
            address       = i_address;
            read          = i_read;
            byteenable    = BYTEENABLE_WORD;
            i_waitrequest = waitrequest;
            if (done_i) begin
               state_next = pick_state;
            end else if (!req_i) begin
               state_next = ARB_IDLE;
            end
         end
         ARB_GRANT_D: begin
            address       = d_address;
            read          = d_read;
            write         = d_write;
            writedata     = d_writedata;
            byteenable    = d_byteenable;
            d_waitrequest = waitrequest;
            if (done_d) begin
               state_next = pick_state;
            end else if (!req_d) begin
               state_next = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   assign i_readdata = readdata;
   assign d_readdata = readdata;
   assign grant_i    = (state == ARB_GRANT_I);
   assign grant_d    = (state == ARB_GRANT_D);

   // State, grant history and starvation counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         last_grant <= SEL_D;
         starve_cnt <= 4'd0;
      end else begin
         state <= state_next;
         if (done_i || done_d) begin
            last_grant <= pick_last;
         end
         if (state_next == ARB_GRANT_I) begin
            starve_cnt <= 4'd0;
         end else if (done_d) begin
            starve_cnt <= pick_cnt;
         end
      end
   end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for both arbitration modes of avalon_bus_arbiter
module tb_avalon_bus_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      logic        gi;
      logic        gd;
      logic        iw;
      logic        dw;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
   } cyc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = 32'h0;

   int vectors = 0;
   int miscompares = 0;
   bit end_req = 1'b0;
   bit sat = 1'b0;

   // Commands published to both requester pairs each cycle
   bit          cmd_i = 0, cmd_d = 0, cmd_ab_i = 0, cmd_ab_d = 0;
   logic [31:0] cmd_i_addr = 0, cmd_d_addr = 0, cmd_d_data = 0;
   logic        cmd_d_wr = 0;
   logic [3:0]  cmd_d_be = 0;
   bit          st_i = 0, st_d = 0, st_ab_i = 0, st_ab_d = 0;
   logic [31:0] st_i_addr = 0, st_d_addr = 0, st_d_data = 0;
   logic        st_d_wr = 0;
   logic [3:0]  st_d_be = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_inst
      localparam bit RR = (k == 0);
      localparam int SL = 4;

      logic [31:0] i_address = 0, d_address = 0, d_writedata = 0;
      logic        i_read = 0, d_read = 0, d_write = 0;
      logic [3:0]  d_byteenable = 0;
      logic        i_waitrequest, d_waitrequest, read, write, grant_i, grant_d;
      logic [31:0] i_readdata, d_readdata, address, writedata;
      logic [3:0]  byteenable;

      req_t  iq[$];
      req_t  dq[$];
      xfer_t xq[$];
      cyc_t  cq[$];
      int    owner = 0;
      int    last = 2;
      int    cnt = 0;
      bit    mvalid = 0;

      avalon_bus_arbiter #(
         .ROUND_ROBIN  (RR),
         .STARVE_LIMIT (SL)
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .i_address     (i_address),
         .i_read        (i_read),
         .i_waitrequest (i_waitrequest),
         .i_readdata    (i_readdata),
         .d_address     (d_address),
         .d_read        (d_read),
         .d_write       (d_write),
         .d_writedata   (d_writedata),
         .d_byteenable  (d_byteenable),
         .d_waitrequest (d_waitrequest),
         .d_readdata    (d_readdata),
         .address       (address),
         .read          (read),
         .write         (write),
         .writedata     (writedata),
         .byteenable    (byteenable),
         .waitrequest   (waitrequest),
         .readdata      (readdata),
         .grant_i       (grant_i),
         .grant_d       (grant_d)
      );

      function automatic int pick(bit ri, bit rd, int lst, int c);
         if (!ri && !rd) return 0;
         if (ri && !rd) return 1;
         if (rd && !ri) return 2;
         if (RR) return (lst == 2) ? 1 : 2;
         return (c >= SL) ? 1 : 2;
      endfunction

      // Requesters: each presents the head of its queue until the reference model says it was taken
      initial forever begin
         req_t r;
         @(posedge clk);
         #2;
         if (cmd_ab_i && iq.size() > 0) r = iq.pop_front();
         if (cmd_ab_d && dq.size() > 0) r = dq.pop_front();
         if (cmd_i) iq.push_back('{cmd_i_addr, 1'b0, 32'h0, 4'hf});
         if (cmd_d) dq.push_back('{cmd_d_addr, cmd_d_wr, cmd_d_data, cmd_d_be});
         if (sat && iq.size() == 0) iq.push_back('{$urandom, 1'b0, 32'h0, 4'hf});
         if (sat && dq.size() == 0)
            dq.push_back('{$urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15))});
         i_read       = (iq.size() > 0);
         i_address    = (iq.size() > 0) ? iq[0].addr : 32'h0;
         d_read       = (dq.size() > 0) && !dq[0].wr;
         d_write      = (dq.size() > 0) && dq[0].wr;
         d_address    = (dq.size() > 0) ? dq[0].addr : 32'h0;
         d_writedata  = (dq.size() > 0) ? dq[0].wdata : 32'h0;
         d_byteenable = (dq.size() > 0) ? dq[0].be : 4'h0;
      end

      // Reference model: who owns the bus this cycle, what completes, who owns it next
      initial forever begin
         cyc_t c;
         bit   ri, rd, rx, done;
         req_t r;
         @(negedge clk);
         ri   = i_read;
         rd   = d_read | d_write;
         rx   = (owner == 1) ? ri : (owner == 2) ? rd : 1'b0;
         done = mvalid && owner != 0 && rx && !waitrequest;
         if (mvalid) begin
            c.gi   = (owner == 1);
            c.gd   = (owner == 2);
            c.iw   = (owner == 1) ? waitrequest : 1'b1;
            c.dw   = (owner == 2) ? waitrequest : 1'b1;
            c.rd   = (owner == 1) ? i_read : (owner == 2) ? d_read : 1'b0;
            c.wr   = (owner == 2) ? d_write : 1'b0;
            c.addr = (owner == 1) ? i_address : (owner == 2) ? d_address : 32'h0;
            cq.push_back(c);
         end
         if (done) begin
            xq.push_back('{owner, (owner == 1) ? i_address : d_address,
                           (owner == 2) ? d_write : 1'b0, d_writedata,
                           (owner == 1) ? 4'hf : d_byteenable, readdata});
            if (owner == 1) r = iq.pop_front();
            else            r = dq.pop_front();
         end
         if (!reset) begin
            owner  = 0;
            last   = 2;
            cnt    = 0;
            mvalid = 1;
         end else if (mvalid) begin
            if (owner == 0) begin
               owner = pick(ri, rd, last, cnt);
            end else if (done) begin
               last = owner;
               if (owner == 2 && ri) cnt = (cnt < 15) ? cnt + 1 : 15;
               owner = pick(ri, rd, last, cnt);
            end else if (!rx) begin
               owner = 0;
            end
            if (owner == 1) cnt = 0;
         end
      end

      // Monitor: per-cycle grant/stall/bus status, plus every completed bus transfer
      initial forever begin
         cyc_t        c;
         xfer_t       x;
         logic [37:0] got_c, exp_c;
         logic [100:0] got_x, exp_x;
         @(negedge clk);
         #1;
         if (cq.size() > 0) begin
            c = cq.pop_front();
            got_c = {grant_i, grant_d, i_waitrequest, d_waitrequest, read, write, address};
            exp_c = {c.gi, c.gd, c.iw, c.dw, c.rd, c.wr, c.addr};
            vectors++;
            if (got_c !== exp_c) begin
               miscompares++;
               $display("FAIL ctl inst=%0d t=%0t got=%h exp=%h", k, $time, got_c, exp_c);
            end
            if ((read || write) && !waitrequest) begin
               vectors++;
               if (xq.size() == 0) begin
                  miscompares++;
                  $display("FAIL xfer inst=%0d t=%0t unexpected transfer addr=%h exp none", k, $time, address);
               end else begin
                  x = xq.pop_front();
                  got_x = {address, write, byteenable, (x.port == 1) ? i_readdata : d_readdata,
                           write ? writedata : 32'h0};
                  exp_x = {x.addr, x.wr, x.be, x.rdata, x.wr ? x.wdata : 32'h0};
                  if (got_x !== exp_x) begin
                     miscompares++;
                     $display("FAIL xfer inst=%0d t=%0t got=%h exp=%h", k, $time, got_x, exp_x);
                  end
               end
            end
         end
      end

      // Nothing the model expected may be left outstanding
      initial begin
         wait (end_req);
         vectors++;
         if (xq.size() != 0 || cq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover inst=%0d got xfers=%0d cycles=%0d exp 0", k, xq.size(), cq.size());
         end
      end
   end

   task automatic stage_i(input logic [31:0] a);
      st_i      = 1;
      st_i_addr = a;
   endtask

   task automatic stage_d(input logic [31:0] a, input logic wr, input logic [31:0] dat, input logic [3:0] be);
      st_d      = 1;
      st_d_addr = a;
      st_d_wr   = wr;
      st_d_data = dat;
      st_d_be   = be;
   endtask

   task automatic tick(input logic rst_n, input logic wreq);
      @(posedge clk);
      #1;
      reset       = rst_n;
      waitrequest = wreq;
      readdata    = $urandom;
      cmd_i = st_i; cmd_i_addr = st_i_addr;
      cmd_d = st_d; cmd_d_addr = st_d_addr; cmd_d_wr = st_d_wr;
      cmd_d_data = st_d_data; cmd_d_be = st_d_be;
      cmd_ab_i = st_ab_i; cmd_ab_d = st_ab_d;
      st_i = 0; st_d = 0; st_ab_i = 0; st_ab_d = 0;
   endtask

   initial begin
      tick(0, 0);
      tick(0, 0);
      // Single instruction fetch from the reset vector
      stage_i(32'hBFC00000);
      for (int i = 0; i < 4; i++) tick(1, 0);
      // Contention straight after reset
      tick(0, 0);
      stage_i(32'h00000100);
      stage_d(32'h00000200, 1'b1, 32'hDEADBEEF, 4'b0011);
      for (int i = 0; i < 5; i++) tick(1, 0);
      // Data read held off by three wait cycles while I waits
      stage_d(32'h00000300, 1'b0, 32'h0, 4'hf);
      tick(1, 1);
      stage_i(32'h00000400);
      for (int i = 0; i < 3; i++) tick(1, 1);
      for (int i = 0; i < 4; i++) tick(1, 0);
      // Reset in the middle of a stalled data transfer
      stage_d(32'h00000500, 1'b0, 32'h0, 4'hf);
      tick(1, 1);
      tick(1, 1);
      tick(0, 1);
      for (int i = 0; i < 4; i++) tick(1, 0);
      // Data requester aborts while stalled, pending I takes over
      stage_d(32'h00000600, 1'b0, 32'h0, 4'hf);
      tick(1, 1);
      tick(1, 1);
      stage_i(32'h00000700);
      tick(1, 1);
      st_ab_d = 1;
      tick(1, 1);
      for (int i = 0; i < 4; i++) tick(1, 0);
      // Both requesters saturated on a zero-wait bus
      sat = 1;
      for (int i = 0; i < 40; i++) tick(1, 0);
      sat = 0;
      for (int i = 0; i < 6; i++) tick(1, 0);
      // Random traffic, stalls, aborts and occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0) stage_i($urandom);
         if ($urandom_range(0, 2) == 0)
            stage_d($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
         st_ab_i = ($urandom_range(0, 24) == 0);
         st_ab_d = ($urandom_range(0, 24) == 0);
         tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < 10; i++) tick(1, 0);
      @(negedge clk);
      #3;
      end_req = 1;
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
